// File: rtl/regfile_rename_pkg.sv
// Shared definitions for the rename register file: tag encoding, default widths
// and helpers for pulling one channel out of a packed CDB bus.
package regfile_rename_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int NREG_DEF    = 32;
    localparam int TAG_W_DEF   = 4;
    localparam int NUM_CDB_DEF = 2;

    // Tag value meaning "no pending producer"; cast to TAG_W at the use site.
    localparam int TAG_NONE = 0;

    localparam int BUS_MAX   = 1024;
    localparam int SLICE_MAX = 64;

    // Returns field idx of width w from a packed bus, zero-extended to SLICE_MAX bits.
    function automatic logic [SLICE_MAX-1:0] slice_at(input logic [BUS_MAX-1:0] bus,
                                                      input int idx,
                                                      input int w);
        logic [BUS_MAX-1:0]   shifted;
        logic [SLICE_MAX-1:0] mask;
        shifted = bus >> (idx * w);
        mask    = (w >= SLICE_MAX) ? '1 : ((SLICE_MAX'(1) << w) - SLICE_MAX'(1));
        return SLICE_MAX'(shifted) & mask;
    endfunction

endpackage

// File: rtl/regfile_rename_if.sv
// Issue, CDB writeback and source-read signals of the rename register file.
interface regfile_rename_if
    import regfile_rename_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int NUM_CDB = NUM_CDB_DEF
);
    localparam int IDX_W = $clog2(NREG);

    logic                       rdy_in;
    logic                       inst_valid;
    logic [IDX_W-1:0]           rd;
    logic [IDX_W-1:0]           rs1;
    logic [IDX_W-1:0]           rs2;
    logic [TAG_W-1:0]           rd_tag;
    logic [NUM_CDB-1:0]         cdb_active;
    logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
    logic [NUM_CDB*XLEN-1:0]    cdb_val;
    logic                       flush_in;
    logic [XLEN-1:0]            vj;
    logic [XLEN-1:0]            vk;
    logic [TAG_W-1:0]           qj;
    logic [TAG_W-1:0]           qk;
    logic [NREG-1:0]            busy_mask;

    modport master (
        output rdy_in, inst_valid, rd, rs1, rs2, rd_tag,
               cdb_active, cdb_tag, cdb_val, flush_in,
        input  vj, vk, qj, qk, busy_mask
    );

    modport slave (
        input  rdy_in, inst_valid, rd, rs1, rs2, rd_tag,
               cdb_active, cdb_tag, cdb_val, flush_in,
        output vj, vk, qj, qk, busy_mask
    );

endinterface

// File: rtl/regfile_rename_cdb_match.sv
// Looks one rename tag up on the CDB; reports a hit and the value of the
// lowest-index active channel carrying that tag.
module cdb_match
    import regfile_rename_pkg::*;
#(
    parameter int NUM_CDB = NUM_CDB_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int XLEN    = XLEN_DEF
) (
    input  logic [TAG_W-1:0]         lookup_tag,
    input  logic [NUM_CDB-1:0]       cdb_active,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
    output logic                     hit,
    output logic [XLEN-1:0]          hit_val
);

    // Scan from the top channel down so the lowest matching index is the last to assign.
    always_comb begin
        hit     = 1'b0;
        hit_val = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_active[k] && lookup_tag != TAG_W'(TAG_NONE) &&
                TAG_W'(slice_at(BUS_MAX'(cdb_tag), k, TAG_W)) == lookup_tag) begin
                hit     = 1'b1;
                hit_val = XLEN'(slice_at(BUS_MAX'(cdb_val), k, XLEN));
            end
        end
    end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags: combinational source
// read with CDB forwarding, CDB writeback, issue rename and mispredict flush.
module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int NUM_CDB = NUM_CDB_DEF
) (
    input  logic           clk_in,
    input  logic           rst_in,
    regfile_rename_if.slave rf
);

    localparam logic [TAG_W-1:0] NONE = TAG_W'(TAG_NONE);

    logic [XLEN-1:0]  val_q [NREG];
    logic [TAG_W-1:0] dep_q [NREG];
    logic [NREG-1:0]  busy_q;

    logic [XLEN-1:0]  val_n [NREG];
    logic [TAG_W-1:0] dep_n [NREG];
    logic [NREG-1:0]  busy_n;

    logic [NREG-1:0]  wb_hit;
    logic [XLEN-1:0]  wb_val [NREG];

    logic             fwd1_hit, fwd2_hit;
    logic [XLEN-1:0]  fwd1_val, fwd2_val;
    logic [TAG_W-1:0] src1_dep, src2_dep;

    logic [XLEN-1:0]  vj_c, vk_c;
    logic [TAG_W-1:0] qj_c, qk_c;

    for (genvar i = 0; i < NREG; i++) begin : g_wb
        cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_wb (
            .lookup_tag (dep_q[i]),
            .cdb_active (rf.cdb_active),
            .cdb_tag    (rf.cdb_tag),
            .cdb_val    (rf.cdb_val),
            .hit        (wb_hit[i]),
            .hit_val    (wb_val[i])
        );
    end

    assign src1_dep = dep_q[rf.rs1];
    assign src2_dep = dep_q[rf.rs2];

    cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_fwd1 (
        .lookup_tag (src1_dep),
        .cdb_active (rf.cdb_active),
        .cdb_tag    (rf.cdb_tag),
        .cdb_val    (rf.cdb_val),
        .hit        (fwd1_hit),
        .hit_val    (fwd1_val)
    );

    cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_fwd2 (
        .lookup_tag (src2_dep),
        .cdb_active (rf.cdb_active),
        .cdb_tag    (rf.cdb_tag),
        .cdb_val    (rf.cdb_val),
        .hit        (fwd2_hit),
        .hit_val    (fwd2_val)
    );

    // Sources see pre-issue state, so a self-dependent rd never reads its own new tag.
    always_comb begin
        vj_c = '0;
        qj_c = NONE;
        vk_c = '0;
        qk_c = NONE;
        if (rst_in && rf.inst_valid && rf.rs1 != '0) begin
            if (src1_dep == NONE) vj_c = val_q[rf.rs1];
            else if (fwd1_hit)    vj_c = fwd1_val;
            else                  qj_c = src1_dep;
        end
        if (rst_in && rf.inst_valid && rf.rs2 != '0) begin
            if (src2_dep == NONE) vk_c = val_q[rf.rs2];
            else if (fwd2_hit)    vk_c = fwd2_val;
            else                  qk_c = src2_dep;
        end
    end

    assign rf.vj        = vj_c;
    assign rf.vk        = vk_c;
    assign rf.qj        = qj_c;
    assign rf.qk        = qk_c;
    assign rf.busy_mask = busy_q;

    // Entry 0 never holds a tag, so its writeback matcher never hits and it stays zero.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            val_n[i] = val_q[i];
            dep_n[i] = dep_q[i];
            if (wb_hit[i]) begin
                val_n[i] = wb_val[i];
                dep_n[i] = NONE;
            end
        end
        if (rf.flush_in) begin
            for (int i = 0; i < NREG; i++) dep_n[i] = NONE;
        end else if (rf.inst_valid && rf.rd != '0) begin
            dep_n[rf.rd] = rf.rd_tag;
        end
        for (int i = 0; i < NREG; i++) busy_n[i] = (dep_n[i] != NONE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                dep_q[i] <= NONE;
            end
            busy_q <= '0;
        end else if (rf.rdy_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= val_n[i];
                dep_q[i] <= dep_n[i];
            end
            busy_q <= busy_n;
        end
    end

endmodule
